shift_sequencer: RTL

//  Command-driven controller sitting directly upstream of the 8-bit universal shift register (uni_shifter).

---
 rtl/shift_seq_pkg.sv | 6 +
 rtl/shift_amt_counter.sv | 20 ++
 rtl/shift_sequencer.sv | 77 +++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: opcode and state encodings shared by the shift sequencer
package shift_seq_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR} op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/shift_amt_counter.sv
// shift_amt_counter: loadable down-counter flagging the final shift cycle
module shift_amt_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] amt,
  input  logic             dec,
  output logic             last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? amt : dec ? cnt_q - 1'b1 : cnt_q;
    last  = cnt_q == CNT_W'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: runs one load/shift command on an external universal shifter
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             c,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] sh_d,
  output logic             sh_i,
  output logic             sh_l,
  output logic             sh_r,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             accept, last, loading, shifting, unused_q;
  assign unused_q = ^q_fb[WIDTH-2:1];
  shift_amt_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (c),
    .rst (rst),
    .load(accept),
    .amt (cmd_amt),
    .dec (shifting),
    .last(last)
  );
  always_comb begin
    cmd_ready = ~rst & (state_q == ST_IDLE);
    accept    = cmd_valid & cmd_ready;
    loading   = state_q == ST_LOAD;
    shifting  = state_q == ST_SHIFT;
    op_d      = accept ? op_t'(cmd_op) : op_q;
    data_d    = accept ? cmd_data : data_q;
    err_d     = accept ? cmd_op > OP_W'(OP_ASR) : (state_q == ST_DONE) ? 1'b0 : err_q;
    state_d   = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (cmd_op > OP_W'(OP_ASR)) ? ST_DONE :
                                      (cmd_op == OP_W'(OP_LOAD)) ? ST_LOAD :
                                      (cmd_amt == '0) ? ST_DONE : ST_SHIFT;
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    busy    = state_q != ST_IDLE;
    done    = state_q == ST_DONE;
    cmd_err = done & err_q;
    sh_d    = loading ? data_q : '0;
    sh_l    = loading | (shifting & (op_q == OP_SHL || op_q == OP_ROL));
    sh_r    = loading | (shifting & (op_q == OP_SHR || op_q == OP_ROR || op_q == OP_ASR));
    // rotates and ASR recirculate a bit from the shifter's own output
    sh_i    = shifting & ((op_q == OP_ROL || op_q == OP_ASR) ? q_fb[WIDTH-1] :
                          (op_q == OP_ROR) ? q_fb[0] : 1'b0);
  end
  always_ff @(posedge c or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
endmodule
